// File: rtl/freq_meter.sv
// Gated frequency meter: counts synchronised rising edges of sig_in over back-to-back
// windows of GATE_CYCLES reference clocks and publishes one saturating result per window.
module freq_meter #(
  parameter int GATE_CYCLES = 1000,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 sig_in,
  output logic [CNT_WIDTH-1:0] freq_count,
  output logic                 overflow,
  output logic                 count_valid,
  output logic                 busy,
  output logic                 state_dbg
);

  localparam int GW = $clog2(GATE_CYCLES);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] GATE = 1'b1;

  localparam logic [GW-1:0]        LAST_CYCLE = GW'(GATE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX    = '1;

  logic [0:0]           state;
  logic                 s1, s2, s3;
  logic [GW-1:0]        gate_cnt;
  logic [CNT_WIDTH-1:0] edge_cnt;
  logic                 ovf;

  logic                 sig_edge;
  logic                 at_max;
  logic                 sat_now;
  logic [CNT_WIDTH-1:0] edge_cnt_next;

  // s1/s2 form the synchroniser; s3 only delays s2 for rising-edge detection.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= sig_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign sig_edge      = s2 & ~s3;
  assign at_max        = (edge_cnt == CNT_MAX);
  assign sat_now       = sig_edge & at_max;
  assign edge_cnt_next = (sig_edge && !at_max) ? edge_cnt + CNT_WIDTH'(1) : edge_cnt;

  assign busy      = (state == GATE);
  assign state_dbg = state;

  // The closing cycle folds its own edge into the published result, so windows stay contiguous.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      gate_cnt    <= '0;
      edge_cnt    <= '0;
      ovf         <= 1'b0;
      freq_count  <= '0;
      overflow    <= 1'b0;
      count_valid <= 1'b0;
    end else begin
      count_valid <= 1'b0;
      case (state)
        IDLE: begin
          gate_cnt <= '0;
          edge_cnt <= '0;
          ovf      <= 1'b0;
          if (enable) state <= GATE;
        end
        GATE: begin
          if (!enable) begin
            state    <= IDLE;
            gate_cnt <= '0;
            edge_cnt <= '0;
            ovf      <= 1'b0;
          end else if (gate_cnt == LAST_CYCLE) begin
            freq_count  <= edge_cnt_next;
            overflow    <= ovf | sat_now;
            count_valid <= 1'b1;
            gate_cnt    <= '0;
            edge_cnt    <= '0;
            ovf         <= 1'b0;
          end else begin
            gate_cnt <= gate_cnt + GW'(1);
            edge_cnt <= edge_cnt_next;
            ovf      <= ovf | sat_now;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_freq_meter.sv
// Bench for freq_meter: two instances (30-cycle/16-bit and 64-cycle/4-bit) share all inputs
// and are compared every cycle against a window-counting model, plus literal scenario checks.
module tb_freq_meter;

  logic        clock;
  logic        reset;
  logic        enable;
  logic        sig_in;

  logic [15:0] a_count;
  logic        a_ovf, a_valid, a_busy, a_state;
  logic [3:0]  b_count;
  logic        b_ovf, b_valid, b_busy, b_state;

  int n_tests = 0;
  int n_fail  = 0;

  freq_meter #(.GATE_CYCLES(30), .CNT_WIDTH(16)) dut_a (
    .clock(clock), .reset(reset), .enable(enable), .sig_in(sig_in),
    .freq_count(a_count), .overflow(a_ovf), .count_valid(a_valid),
    .busy(a_busy), .state_dbg(a_state)
  );

  freq_meter #(.GATE_CYCLES(64), .CNT_WIDTH(4)) dut_b (
    .clock(clock), .reset(reset), .enable(enable), .sig_in(sig_in),
    .freq_count(b_count), .overflow(b_ovf), .count_valid(b_valid),
    .busy(b_busy), .state_dbg(b_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Divide-by-3 toggle divider on a 4 ns clock: sig period 24 ns, edges never on a clock posedge.
  logic fast_clk;
  logic div_sig;
  int   div_cnt;
  initial begin
    fast_clk = 1'b0;
    forever #2 fast_clk = ~fast_clk;
  end
  initial begin
    div_sig = 1'b0;
    div_cnt = 0;
  end
  always @(posedge fast_clk) begin
    if (div_cnt == 2) begin
      div_cnt = 0;
      div_sig = ~div_sig;
    end else begin
      div_cnt = div_cnt + 1;
    end
  end

  // ---------------- sig_in pattern driver ----------------
  int   mode     = 0;  // 0 hold, 1 period 3 (1 high/2 low), 2 period 2, 3 random runs
  bit   sig_hold = 1'b0;
  bit   use_div  = 1'b0;
  logic sig_drv  = 1'b0;
  int   ph       = 0;
  int   run_left = 0;

  always @(negedge clock) begin
    ph = ph + 1;
    case (mode)
      0: sig_drv = sig_hold;
      1: sig_drv = (ph % 3 == 0);
      2: sig_drv = ph[0];
      default: begin
        if (run_left == 0) begin
          sig_drv  = ~sig_drv;
          run_left = $urandom_range(0, 2);
        end else begin
          run_left = run_left - 1;
        end
      end
    endcase
  end

  assign sig_in = use_div ? div_sig : sig_drv;

  // ---------------- behavioural model ----------------
  // Edges are rises of sig_in as sampled on the clock, seen two sample periods late.
  // A window opens the cycle after enable is seen in idle and spans G cycles.
  int G  [2] = '{30, 64};
  int MX [2] = '{65535, 15};
  bit m_in    [2];
  int m_pos   [2];
  int m_n     [2];
  bit m_valid [2];
  int m_cnt   [2];
  bit m_ovf   [2];
  bit h1, h2, h3, m_edge;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      h1 = 0; h2 = 0; h3 = 0;
      for (int d = 0; d < 2; d++) begin
        m_in[d] = 0; m_pos[d] = 0; m_n[d] = 0;
        m_valid[d] = 0; m_cnt[d] = 0; m_ovf[d] = 0;
      end
    end else begin
      m_edge = h2 & ~h3;
      for (int d = 0; d < 2; d++) begin
        m_valid[d] = 0;
        if (!m_in[d]) begin
          if (enable) begin
            m_in[d] = 1; m_pos[d] = 0; m_n[d] = 0;
          end
        end else if (!enable) begin
          m_in[d] = 0;
        end else begin
          m_n[d] = m_n[d] + int'(m_edge);
          if (m_pos[d] == G[d] - 1) begin
            m_valid[d] = 1;
            m_cnt[d]   = (m_n[d] > MX[d]) ? MX[d] : m_n[d];
            m_ovf[d]   = (m_n[d] > MX[d]);
            m_pos[d]   = 0;
            m_n[d]     = 0;
          end else begin
            m_pos[d] = m_pos[d] + 1;
          end
        end
      end
      h3 = h2; h2 = h1; h1 = sig_in;
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clock) begin
    #1;
    check("a_valid", int'(a_valid), int'(m_valid[0]));
    check("a_count", int'(a_count), m_cnt[0]);
    check("a_ovf",   int'(a_ovf),   int'(m_ovf[0]));
    check("a_busy",  int'(a_busy),  int'(m_in[0]));
    check("b_valid", int'(b_valid), int'(m_valid[1]));
    check("b_count", int'(b_count), m_cnt[1]);
    check("b_ovf",   int'(b_ovf),   int'(m_ovf[1]));
    check("b_busy",  int'(b_busy),  int'(m_in[1]));
  end

  task automatic wait_strobe(input int d, output int cyc, output int cnt, output int ovf);
    cyc = 0; cnt = -1; ovf = -1;
    for (int i = 0; i < 200; i++) begin
      @(posedge clock);
      #1;
      cyc++;
      if ((d == 0) ? a_valid : b_valid) begin
        cnt = (d == 0) ? int'(a_count) : int'(b_count);
        ovf = (d == 0) ? int'(a_ovf) : int'(b_ovf);
        return;
      end
    end
    n_tests++;
    n_fail++;
    $display("FAIL strobe_timeout dut%0d: no count_valid within 200 cycles", d);
  endtask

  // ---------------- stimulus ----------------
  int cyc, cnt, ovf;

  initial begin
    reset  = 1'b0;
    enable = 1'b0;
    repeat (3) @(negedge clock);
    check("reset_a_count", int'(a_count), 0);
    check("reset_a_valid", int'(a_valid), 0);
    check("reset_a_busy",  int'(a_busy),  0);
    check("reset_b_ovf",   int'(b_ovf),   0);
    reset = 1'b1;

    // Periodic input, 3-clock period: 10 edges per 30-cycle window.
    mode = 1;
    @(negedge clock);
    enable = 1'b1;
    wait_strobe(0, cyc, cnt, ovf);
    check("t1_first_latency", cyc, 31);
    wait_strobe(0, cyc, cnt, ovf);
    check("t1_spacing", cyc, 30);
    check("t1_count", cnt, 10);
    check("t1_ovf", ovf, 0);
    wait_strobe(0, cyc, cnt, ovf);
    check("t1_count_again", cnt, 10);

    // Saturation on the 4-bit instance, then recovery with a quiet input.
    mode = 2;
    wait_strobe(1, cyc, cnt, ovf);
    wait_strobe(1, cyc, cnt, ovf);
    check("t2_sat_count", cnt, 15);
    check("t2_sat_ovf", ovf, 1);
    mode = 0;
    sig_hold = 1'b0;
    wait_strobe(1, cyc, cnt, ovf);
    wait_strobe(1, cyc, cnt, ovf);
    check("t2_quiet_count", cnt, 0);
    check("t2_quiet_ovf", ovf, 0);

    // Abort at gate_cnt 12, hold, then re-enable.
    mode = 1;
    wait_strobe(0, cyc, cnt, ovf);
    wait_strobe(0, cyc, cnt, ovf);
    check("t3_pre_count", cnt, 10);
    repeat (12) @(posedge clock);
    @(negedge clock);
    enable = 1'b0;
    @(posedge clock);
    #1;
    check("t3_busy_drop", int'(a_busy), 0);
    for (int i = 0; i < 40; i++) begin
      @(posedge clock);
      #1;
      check("t3_hold_count", int'(a_count), 10);
      check("t3_no_valid", int'(a_valid), 0);
    end
    @(negedge clock);
    enable = 1'b1;
    wait_strobe(0, cyc, cnt, ovf);
    check("t3_resume_latency", cyc, 31);
    wait_strobe(0, cyc, cnt, ovf);
    check("t3_resume_spacing", cyc, 30);
    check("t3_resume_count", cnt, 10);

    // Asynchronous reset mid-window.
    repeat (7) @(posedge clock);
    #2 reset = 1'b0;
    #1;
    check("t4_async_count", int'(a_count), 0);
    check("t4_async_busy", int'(a_busy), 0);
    check("t4_async_state", int'(a_state), 0);
    check("t4_async_b_ovf", int'(b_ovf), 0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    wait_strobe(0, cyc, cnt, ovf);
    check("t4_release_latency", cyc, 31);

    // Edge landing exactly on the closing cycle belongs to that window.
    @(negedge clock);
    enable = 1'b0;
    mode = 0;
    sig_hold = 1'b0;
    repeat (4) @(negedge clock);
    enable = 1'b1;
    @(posedge clock);
    repeat (27) @(posedge clock);
    #1 sig_hold = 1'b1;
    wait_strobe(0, cyc, cnt, ovf);
    check("t6_close_cycles", cyc, 3);
    check("t6_close_count", cnt, 1);
    repeat (3) @(posedge clock);
    #1 sig_hold = 1'b0;
    wait_strobe(0, cyc, cnt, ovf);
    check("t6_next_count", cnt, 0);

    // Divider input: expect 30*10/24 = 12.5 edges, within +/-1.
    @(negedge clock);
    use_div = 1'b1;
    wait_strobe(0, cyc, cnt, ovf);
    for (int w = 0; w < 20; w++) begin
      wait_strobe(0, cyc, cnt, ovf);
      n_tests++;
      if (cnt * 24 < 300 - 24 || cnt * 24 > 300 + 24) begin
        n_fail++;
        $display("FAIL t5_div_window%0d: got %0d expected 12..13", w, cnt);
      end
    end

    // Random runs with occasional enable drops, checked by the per-cycle model.
    @(negedge clock);
    use_div = 1'b0;
    mode = 3;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clock);
      if (enable && $urandom_range(0, 99) == 0) enable = 1'b0;
      else if (!enable && $urandom_range(0, 4) == 0) enable = 1'b1;
    end

    @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
